// File: rtl/timer_pkg.sv
// Shared definitions for the timer event controller: register map, bit positions,
// FSM state encoding and default widths.
package timer_pkg;

    localparam int TMR_CNT_W = 24;
    localparam int TMR_EXP_W = 8;

    localparam logic [1:0] TMR_CTRL   = 2'd0;
    localparam logic [1:0] TMR_RELOAD = 2'd1;
    localparam logic [1:0] TMR_STATUS = 2'd2;
    localparam logic [1:0] TMR_COUNT  = 2'd3;

    localparam int CTRL_EN_BIT       = 0;
    localparam int CTRL_IRQ_EN_BIT   = 1;
    localparam int CTRL_PERIODIC_BIT = 2;
    localparam int STAT_PEND_BIT     = 0;
    localparam int STAT_EXP_LSB      = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ARM,
        ST_RUN,
        ST_EXPIRE
    } timer_state_t;

endpackage

// File: rtl/timer_event_ctrl.sv
// Timer control stage: register file, counter load sequencing, expiry detection and irq.
// Optional macro TIMER_AUTORELOAD_EN implements CTRL.periodic (auto re-arm on expiry).
//
// state  | meaning
// IDLE   | timer stopped, counter not driven
// LOAD   | load_o high, counter takes max(RELOAD,1)
// ARM    | counter starts decrementing
// RUN    | wait for count_i == 0
// EXPIRE | record expiry; re-load if periodic, else drop enable
module timer_event_ctrl
    import timer_pkg::*;
#(
    parameter int CNT_W = TMR_CNT_W,
    parameter int EXP_W = TMR_EXP_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [1:0]       wr_addr,
    input  logic [CNT_W-1:0] wr_data,
    input  logic [1:0]       rd_addr,
    output logic [CNT_W-1:0] rd_data,
    input  logic [CNT_W-1:0] count_i,
    output logic             load_o,
    output logic [CNT_W-1:0] load_value_o,
    output logic             irq
);

    timer_state_t     state;
    timer_state_t     state_nxt;
    logic             enable;
    logic             irq_en;
    logic             periodic;
    logic             pending;
    logic [CNT_W-1:0] reload;
    logic [EXP_W-1:0] exp_cnt;

    logic ctrl_wr;
    logic reload_wr;
    logic stat_clr;
    logic expire;

    assign ctrl_wr   = wr_en && (wr_addr == TMR_CTRL);
    assign reload_wr = wr_en && (wr_addr == TMR_RELOAD);
    assign stat_clr  = wr_en && (wr_addr == TMR_STATUS) && wr_data[STAT_PEND_BIT];
    assign expire    = (state == ST_EXPIRE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (ctrl_wr && wr_data[CTRL_EN_BIT]) state_nxt = ST_LOAD;
            ST_LOAD:   state_nxt = ST_ARM;
            ST_ARM:    state_nxt = ST_RUN;
            ST_RUN:    if (count_i == '0) state_nxt = ST_EXPIRE;
            ST_EXPIRE: state_nxt = periodic ? ST_LOAD : ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
        // Disable overrides everything, including a pending re-arm.
        if (ctrl_wr && !wr_data[CTRL_EN_BIT]) state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable  <= 1'b0;
            irq_en  <= 1'b0;
            reload  <= '0;
            pending <= 1'b0;
            exp_cnt <= '0;
        end else begin
            if (ctrl_wr) begin
                enable <= wr_data[CTRL_EN_BIT];
                irq_en <= wr_data[CTRL_IRQ_EN_BIT];
            end
            if (expire && !periodic) enable <= 1'b0;
            if (reload_wr) reload <= wr_data;
            if (stat_clr) begin
                pending <= 1'b0;
                exp_cnt <= '0;
            end
            // Expiry set beats a same-cycle W1C clear.
            if (expire) begin
                pending <= 1'b1;
                if (stat_clr) begin
                    exp_cnt <= EXP_W'(1);
                end else if (exp_cnt != '1) begin
                    exp_cnt <= exp_cnt + EXP_W'(1);
                end
            end
        end
    end

`ifdef TIMER_AUTORELOAD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            periodic <= 1'b0;
        end else if (ctrl_wr) begin
            periodic <= wr_data[CTRL_PERIODIC_BIT];
        end
    end
`else
    assign periodic = 1'b0;
`endif

    assign load_o       = (state == ST_LOAD);
    assign load_value_o = !load_o ? '0 : ((reload == '0) ? CNT_W'(1) : reload);
    assign irq          = pending & irq_en;

    always_comb begin
        rd_data = '0;
        case (rd_addr)
            TMR_CTRL: begin
                rd_data[CTRL_EN_BIT]       = enable;
                rd_data[CTRL_IRQ_EN_BIT]   = irq_en;
                rd_data[CTRL_PERIODIC_BIT] = periodic;
            end
            TMR_RELOAD: rd_data = reload;
            TMR_STATUS: begin
                rd_data[STAT_PEND_BIT]             = pending;
                rd_data[STAT_EXP_LSB +: EXP_W]     = exp_cnt;
            end
            default: rd_data = count_i;
        endcase
    end

endmodule

// File: tb/tb_timer_event_ctrl.sv
// Self-checking bench for timer_event_ctrl with a behavioural down counter alongside.
module tb_timer_event_ctrl;
    import timer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_addr = 2'd0;
    logic [23:0] wr_data = 24'd0;
    logic [1:0]  rd_addr = 2'd0;
    logic [23:0] rd_data;
    logic [23:0] cnt;
    logic        load_o;
    logic [23:0] load_value;
    logic        irq;

    int total = 0;
    int bad = 0;
    int load_total = 0;

    timer_event_ctrl dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .count_i(cnt), .load_o(load_o),
        .load_value_o(load_value), .irq(irq)
    );

    always #5 clk = ~clk;

    // Sibling down counter: loads on load_o, otherwise counts toward 0 and holds there.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= 24'd0;
        else if (load_o) cnt <= load_value;
        else if (cnt != 24'd0) cnt <= cnt - 24'd1;
    end

    always @(posedge clk) if (load_o) load_total = load_total + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [23:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [23:0] v);
        rd_addr = a;
        #1;
        v = rd_data;
    endtask

    // One-shot run from a cleared status; expiry must land max(R,1)+3 cycles after LOAD.
    task automatic run_oneshot(input int r, input bit ie, input bit midreload, input bit collide);
        int eff;
        int k;
        int found;
        int l0;
        logic [23:0] v;
        eff = (r == 0) ? 1 : r;
        wr(TMR_STATUS, 24'h1);
        wr(TMR_RELOAD, 24'(r));
        l0 = load_total;
        wr(TMR_CTRL, ie ? 24'h3 : 24'h1);
        check("load_pulse", {31'd0, load_o}, 32'd1);
        check("load_value", {8'd0, load_value}, 32'(eff));
        k = 0;
        found = -1;
        while (k < eff + 10 && found < 0) begin
            if (midreload && k == 2) wr(TMR_RELOAD, 24'($urandom_range(200, 900)));
            else if (collide && k == eff + 2) wr(TMR_STATUS, 24'h1);
            else step();
            k++;
            rd(TMR_STATUS, v);
            if (v[0]) found = k;
        end
        check("expiry_cycle", 32'(found), 32'(eff + 3));
        check("irq_level", {31'd0, irq}, {31'd0, ie});
        rd(TMR_CTRL, v);
        check("ctrl_after_oneshot", {8'd0, v}, ie ? 32'h2 : 32'h0);
        if (!collide) begin
            rd(TMR_STATUS, v);
            check("exp_count_one", {24'd0, v[15:8]}, 32'd1);
        end
        repeat (eff + 6) step();
        check("single_load", 32'(load_total - l0), 32'd1);
        wr(TMR_STATUS, 24'h1);
        rd(TMR_STATUS, v);
        check("w1c_clear", {8'd0, v}, 32'd0);
        check("irq_cleared", {31'd0, irq}, 32'd0);
    endtask

    initial begin
        logic [23:0] v;
        logic [23:0] rv;
        int l0;
        int r;

        repeat (2) step();
        check("rst_load_o", {31'd0, load_o}, 32'd0);
        check("rst_load_value", {8'd0, load_value}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        rd(TMR_CTRL, v);   check("rst_ctrl", {8'd0, v}, 32'd0);
        rd(TMR_RELOAD, v); check("rst_reload", {8'd0, v}, 32'd0);
        rst_n = 1'b1;
        step();
        rd(TMR_STATUS, v); check("rst_status", {8'd0, v}, 32'd0);

        // Register access: RELOAD read-back, STATUS writes with bit0=0 do nothing, COUNT mirrors count_i.
        for (int i = 0; i < 6; i++) begin
            rv = 24'($urandom);
            wr(TMR_RELOAD, rv);
            rd(TMR_RELOAD, v); check("reload_rdback", {8'd0, v}, {8'd0, rv});
            wr(TMR_STATUS, 24'($urandom) & 24'hFFFFFE);
            rd(TMR_STATUS, v); check("status_ro", {8'd0, v}, 32'd0);
            rd(TMR_COUNT, v);  check("count_passthru", {8'd0, v}, {8'd0, cnt});
        end

        // Spec example, boundaries and randomized one-shot runs.
        run_oneshot(5, 1'b1, 1'b0, 1'b0);
        run_oneshot(0, 1'b1, 1'b0, 1'b0);
        run_oneshot(1, 1'b0, 1'b0, 1'b0);
        run_oneshot(3, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            r = $urandom_range(2, 40);
            run_oneshot(r, 1'($urandom), (r >= 4) ? 1'($urandom) : 1'b0, 1'($urandom));
        end

        // Expiry count accumulates across one-shot runs.
        wr(TMR_STATUS, 24'h1);
        for (int i = 0; i < 3; i++) begin
            wr(TMR_RELOAD, 24'd2);
            wr(TMR_CTRL, 24'h3);
            repeat (10) step();
        end
        rd(TMR_STATUS, v);
        check("exp_count_accum", {8'd0, v}, 32'h0301);

`ifdef TIMER_AUTORELOAD_EN
        // Periodic: RELOAD=2 gives a load every 5 cycles.
        wr(TMR_STATUS, 24'h1);
        wr(TMR_RELOAD, 24'd2);
        wr(TMR_CTRL, 24'h7);
        l0 = load_total;
        rd(TMR_CTRL, v); check("ctrl_periodic", {8'd0, v}, 32'h7);
        for (int k = 1; k <= 15; k++) begin
            step();
            if (k % 5 == 0) check("periodic_load", {31'd0, load_o}, 32'd1);
            else if (k % 5 == 3) check("periodic_noload", {31'd0, load_o}, 32'd0);
        end
        rd(TMR_STATUS, v); check("periodic_count3", {24'd0, v[15:8]}, 32'd3);
        // Saturation at 255 with a 4-cycle period.
        wr(TMR_RELOAD, 24'd1);
        repeat (270 * 4) step();
        rd(TMR_STATUS, v); check("exp_count_sat", {24'd0, v[15:8]}, 32'd255);
        wr(TMR_CTRL, 24'h0);
        wr(TMR_STATUS, 24'h1);
        repeat (6) step();
`else
        // Periodic bit is not stored: one expiry only, then idle.
        wr(TMR_STATUS, 24'h1);
        wr(TMR_RELOAD, 24'd2);
        l0 = load_total;
        wr(TMR_CTRL, 24'h7);
        rd(TMR_CTRL, v); check("ctrl_no_periodic", {8'd0, v}, 32'h3);
        repeat (30) step();
        check("no_periodic_loads", 32'(load_total - l0), 32'd1);
        rd(TMR_STATUS, v); check("no_periodic_status", {8'd0, v}, 32'h0101);
        rd(TMR_CTRL, v); check("no_periodic_ctrl_end", {8'd0, v}, 32'h2);
        wr(TMR_STATUS, 24'h1);
`endif

        // Disable mid-run.
        wr(TMR_RELOAD, 24'd100);
        l0 = load_total;
        wr(TMR_CTRL, 24'h3);
        repeat (9) step();
        wr(TMR_CTRL, 24'h0);
        repeat (150) step();
        check("disable_loads", 32'(load_total - l0), 32'd1);
        rd(TMR_STATUS, v); check("disable_pending", {8'd0, v}, 32'd0);
        rd(TMR_CTRL, v);   check("disable_ctrl", {8'd0, v}, 32'd0);
        wr(TMR_CTRL, 24'h1);
        check("reenable_load", {31'd0, load_o}, 32'd1);
        wr(TMR_CTRL, 24'h0);

        // Reset mid-run with irq asserted from a previous expiry.
        wr(TMR_RELOAD, 24'd3);
        wr(TMR_CTRL, 24'h3);
        repeat (10) step();
        check("pre_reset_irq", {31'd0, irq}, 32'd1);
        wr(TMR_RELOAD, 24'd50);
        wr(TMR_CTRL, 24'h3);
        check("pre_reset_load", {31'd0, load_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_load", {31'd0, load_o}, 32'd0);
        check("async_rst_value", {8'd0, load_value}, 32'd0);
        check("async_rst_irq", {31'd0, irq}, 32'd0);
        rd(TMR_CTRL, v);   check("async_rst_ctrl", {8'd0, v}, 32'd0);
        rd(TMR_RELOAD, v); check("async_rst_reload", {8'd0, v}, 32'd0);
        rd(TMR_STATUS, v); check("async_rst_status", {8'd0, v}, 32'd0);
        step();
        rst_n = 1'b1;
        l0 = load_total;
        repeat (80) step();
        check("post_reset_noload", 32'(load_total - l0), 32'd0);
        wr(TMR_CTRL, 24'h1);
        check("post_reset_enable", {31'd0, load_o}, 32'd1);
        check("post_reset_value", {8'd0, load_value}, 32'd1);
        repeat (6) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
